// File: rtl/stack_pkg.sv
// Shared definitions for the LIFO stack: operation encodings and a
// constant-evaluable clog2 used to size count and address fields.
package stack_pkg;

    localparam logic [1:0] OP_NONE    = 2'b00;
    localparam logic [1:0] OP_PUSH    = 2'b01;
    localparam logic [1:0] OP_POP     = 2'b10;
    localparam logic [1:0] OP_REPLACE = 2'b11;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stack_regfile.sv
// Stack storage: one synchronous write port and one asynchronous read port.
// Contents are deliberately not reset.
module stack_regfile
    import stack_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/lifo_stack.sv
// LIFO stack controller: occupancy count, flags, sticky errors, replace-top
// and synchronous flush around a stack_regfile.
module lifo_stack
    import stack_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12,
    localparam int CW      = clog2(DEPTH + 1),
    localparam int AW      = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    input  logic              err_clr,
    output logic [DATA_W-1:0] top,
    output logic [CW-1:0]     count,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              ovf,
    output logic              unf
);

    logic [CW-1:0]     r_count;
    logic              r_ovf;
    logic              r_unf;

    logic [1:0]        w_op;
    logic              w_empty;
    logic              w_full;
    logic [AW-1:0]     w_top_addr;
    logic [DATA_W-1:0] w_rdata;
    logic              w_we;
    logic [AW-1:0]     w_waddr;
    logic [CW-1:0]     w_cnt_nxt;
    logic              w_ovf_set;
    logic              w_unf_set;

    assign w_op    = {pop, push};
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    // Address 0 when empty keeps the read in range for non-power-of-two depths.
    assign w_top_addr = w_empty ? '0 : AW'(r_count - CW'(1));

    always_comb begin
        w_we      = 1'b0;
        w_waddr   = AW'(r_count);
        w_cnt_nxt = r_count;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        if (!clr) begin
            case (w_op)
                OP_PUSH: begin
                    if (w_full) begin
                        w_ovf_set = 1'b1;
                    end else begin
                        w_we      = 1'b1;
                        w_cnt_nxt = r_count + CW'(1);
                    end
                end
                OP_POP: begin
                    if (w_empty) begin
                        w_unf_set = 1'b1;
                    end else begin
                        w_cnt_nxt = r_count - CW'(1);
                    end
                end
                OP_REPLACE: begin
                    // On an empty stack the push still lands in slot 0; only the pop is an error.
                    w_we    = 1'b1;
                    w_waddr = w_top_addr;
                    if (w_empty) begin
                        w_cnt_nxt = CW'(1);
                        w_unf_set = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (clr) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_count <= w_cnt_nxt;
            r_ovf   <= w_ovf_set | (r_ovf & ~err_clr);
            r_unf   <= w_unf_set | (r_unf & ~err_clr);
        end
    end

    stack_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_regfile (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (din),
        .raddr (w_top_addr),
        .rdata (w_rdata)
    );

    assign top         = w_empty ? '0 : w_rdata;
    assign count       = r_count;
    assign empty       = w_empty;
    assign full        = w_full;
    assign almost_full = (r_count >= CW'(AF_LEVEL));
    assign ovf         = r_ovf;
    assign unf         = r_unf;

endmodule

// File: tb/tb_lifo_stack.sv
// Scoreboard bench for lifo_stack: a queue-based stack model predicts each
// cycle's outputs; a negedge monitor pops and compares.
module tb_lifo_stack;

    localparam int DATA_W   = 8;
    localparam int DEPTH    = 4;
    localparam int AF_LEVEL = 3;
    localparam int CW       = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              clr = 1'b0;
    logic              push = 1'b0;
    logic              pop = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic              err_clr = 1'b0;
    logic [DATA_W-1:0] top;
    logic [CW-1:0]     count;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic              ovf;
    logic              unf;

    lifo_stack #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clr         (clr),
        .push        (push),
        .pop         (pop),
        .din         (din),
        .err_clr     (err_clr),
        .top         (top),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .ovf         (ovf),
        .unf         (unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        string             tag;
        logic [DATA_W-1:0] top;
        int                count;
        logic              empty;
        logic              full;
        logic              af;
        logic              ovf;
        logic              unf;
    } exp_t;

    exp_t sb[$];
    int   mq[$];
    bit   m_ovf;
    bit   m_unf;
    int   n_vec = 0;
    int   n_err = 0;

    function automatic exp_t snapshot(input string tag);
        exp_t e;
        e.tag   = tag;
        e.count = mq.size();
        e.top   = (mq.size() > 0) ? DATA_W'(mq[$]) : '0;
        e.empty = (mq.size() == 0);
        e.full  = (mq.size() == DEPTH);
        e.af    = (mq.size() >= AF_LEVEL);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        return e;
    endfunction

    task automatic model_apply(input bit c, input bit pu, input bit po,
                               input logic [DATA_W-1:0] d, input bit ec);
        bit new_ovf;
        bit new_unf;
        new_ovf = 1'b0;
        new_unf = 1'b0;
        if (c) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (pu && po) begin
                if (mq.size() == 0) begin
                    mq.push_back(int'(d));
                    new_unf = 1'b1;
                end else begin
                    mq[mq.size()-1] = int'(d);
                end
            end else if (pu) begin
                if (mq.size() == DEPTH) new_ovf = 1'b1;
                else                    mq.push_back(int'(d));
            end else if (po) begin
                if (mq.size() == 0) new_unf = 1'b1;
                else                void'(mq.pop_back());
            end
            m_ovf = new_ovf | (m_ovf & !ec);
            m_unf = new_unf | (m_unf & !ec);
        end
    endtask

    task automatic check(input exp_t e);
        n_vec++;
        if (top !== e.top || int'(count) != e.count || count === 'x || empty !== e.empty ||
            full !== e.full || almost_full !== e.af || ovf !== e.ovf || unf !== e.unf) begin
            n_err++;
            $display("FAIL %s: got top=%h cnt=%0d empty=%b full=%b af=%b ovf=%b unf=%b, expected top=%h cnt=%0d empty=%b full=%b af=%b ovf=%b unf=%b",
                     e.tag, top, count, empty, full, almost_full, ovf, unf,
                     e.top, e.count, e.empty, e.full, e.af, e.ovf, e.unf);
        end
    endtask

    task automatic step(input string tag, input bit c, input bit pu, input bit po,
                        input logic [DATA_W-1:0] d, input bit ec);
        @(negedge clk);
        clr     = c;
        push    = pu;
        pop     = po;
        din     = d;
        err_clr = ec;
        @(posedge clk);
        model_apply(c, pu, po, d, ec);
        sb.push_back(snapshot(tag));
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            check(sb.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        check(snapshot("reset"));

        step("t1_push11", 0, 1, 0, 8'h11, 0);
        step("t1_push22", 0, 1, 0, 8'h22, 0);
        step("t1_push33", 0, 1, 0, 8'h33, 0);
        step("t2_push44", 0, 1, 0, 8'h44, 0);
        step("t2_push55_ovf", 0, 1, 0, 8'h55, 0);
        step("t2_errclr", 0, 0, 0, 8'h00, 1);
        step("t3_pop1", 0, 0, 1, 8'h00, 0);
        step("t3_pop2", 0, 0, 1, 8'h00, 0);
        step("t3_pop3", 0, 0, 1, 8'h00, 0);
        step("t3_pop4", 0, 0, 1, 8'h00, 0);
        step("t3_pop5_unf", 0, 0, 1, 8'h00, 0);
        step("t4_errclr", 0, 0, 0, 8'h00, 1);
        step("t4_push11", 0, 1, 0, 8'h11, 0);
        step("t4_push22", 0, 1, 0, 8'h22, 0);
        step("t4_replace99", 0, 1, 1, 8'h99, 0);
        step("t4_push33", 0, 1, 0, 8'h33, 0);
        step("t4_push44", 0, 1, 0, 8'h44, 0);
        step("t4_replace_full", 0, 1, 1, 8'hAB, 0);
        step("t5_clr", 1, 0, 0, 8'h00, 0);
        step("t5_replace_empty", 0, 1, 1, 8'h7E, 0);
        step("t5_clr_push", 1, 1, 0, 8'h5A, 0);
        step("t5_errclr_vs_set", 0, 0, 1, 8'h00, 1);

        for (int i = 0; i < 4; i++) begin
            step("t6_fill", 0, 1, 0, DATA_W'(8'hA0 + i), 0);
        end
        @(negedge clk);
        push = 1'b1;
        din  = 8'hC3;
        #2 reset = 1'b1;
        #1;
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        check(snapshot("t6_async_reset"));
        @(negedge clk);
        push  = 1'b0;
        reset = 1'b0;

        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 9));
            step("rand",
                 ($urandom_range(0, 15) == 0),
                 (r <= 3) || (r == 7) || (r == 8),
                 (r >= 4) && (r <= 8),
                 DATA_W'($urandom),
                 ($urandom_range(0, 7) == 0));
        end

        step("idle", 0, 0, 0, 8'h00, 0);
        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
